usb_gpx_event_ctrl: RTL and testbench
=====================================

USB_GPX_EVENT_CTRL -- requirements
Module: usb_gpx_event_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive equal synchronized samples needed to accept a new GPX level (range 2..255).
REQ-002 SHALL have parameter CNT_W, default 16, meaning event counter width (range 8..32).
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port address, input, 2, Avalon-MM word address.
REQ-006 SHALL have port read, input, 1, Avalon-MM read strobe.
REQ-007 SHALL have port write, input, 1, Avalon-MM write strobe.
REQ-008 SHALL have port writedata, input, 32, Avalon-MM write data.
REQ-009 SHALL have port readdata, output, 32, registered Avalon-MM read data.
REQ-010 SHALL have port in_port, input, 1, asynchronous USB controller GPX pin.
REQ-011 SHALL have port irq, output, 1, level interrupt to the CPU.

Function
REQ-012 SHALL pass in_port through a 2-flop synchronizer before any other use.
REQ-013 SHALL run debounce FSM states S_LO, S_CHK_HI, S_HI, S_CHK_LO.
- S_LO: sync=1 goes to S_CHK_HI, counter=1.
- S_CHK_HI: counter increments while sync=1; sync=0 returns to S_LO; counter reaching DEBOUNCE_CYCLES goes to S_HI and sets level=1.
- S_HI and S_CHK_LO: mirror image.
REQ-014 SHALL produce a one-cycle rise pulse on the level 0->1 transition and a one-cycle fall pulse on 1->0.
REQ-015 SHALL map registers as follows.
- Address 0, DATA: read-only; bit0=level, bit1=raw synchronized value.
- Address 1, MASK: read/write; bit0=rise enable, bit1=fall enable.
- Address 2, EDGE: bit0=rise, bit1=fall; sticky; write-1-to-clear.
- Address 3, COUNT: read-only count of edges; any write clears it.
REQ-016 SHALL zero unused register bits on read.
REQ-017 SHALL register readdata one cycle after read=1; readdata SHALL hold its value when read=0.
REQ-018 SHALL drive irq registered as OR(EDGE & MASK[1:0]); irq rises 1 cycle after the capture bit sets.
REQ-019 SHALL resolve a same-cycle edge pulse and W1C of that bit in favour of set.
REQ-020 SHALL set COUNT=1 when a clear write and an edge pulse occur in the same cycle.
REQ-021 SHALL saturate COUNT at 2^CNT_W-1 and not wrap.
REQ-022 SHALL ignore writes to addresses 0 and 3 except for the COUNT clear.

Reset
REQ-023 SHALL, on reset, set the synchronizer to 0, FSM to S_LO, level to 0, MASK to 0, EDGE to 0, COUNT to 0, readdata to 0 and irq to 0.
REQ-024 SHALL let reset asserted mid-debounce abandon the check; a high in_port after reset SHALL be reported as a rise once debounced.

Configuration
REQ-025 SHALL compile in the debounce FSM only when macro USB_GPX_DEBOUNCE_EN is defined.
REQ-026 SHALL, without USB_GPX_DEBOUNCE_EN, set level equal to the synchronized value, omit the FSM and ignore DEBOUNCE_CYCLES.

Structure
REQ-027 SHALL place the register address constants, the EDGE/MASK bit indices and the debounce state enum in shared package usb_gpx_pkg.
REQ-028 SHALL implement synchronizer plus debounce as sub-module usb_gpx_debounce, with outputs level, rise and fall.

Verification
REQ-029 SHALL test debounce accept: DEBOUNCE_CYCLES=4, in_port high 8 cycles -> level=1 after 2+4 cycles, EDGE=0x1, COUNT=1.
REQ-030 SHALL test glitch reject: in_port high 3 cycles, then low (DEBOUNCE_CYCLES=4) -> level stays 0, EDGE=0, COUNT=0.
REQ-031 SHALL test interrupt: MASK=0x2, full high-then-low pulse -> irq=1 only after the fall; writing EDGE=0x2 -> irq=0 next cycle, EDGE=0x1 remains.
REQ-032 SHALL test set-wins: W1C of EDGE bit0 in the same cycle as a rise pulse -> EDGE bit0 reads 1.
REQ-033 SHALL test saturation: CNT_W=8, 300 debounced edges -> COUNT=255; write to address 3 -> COUNT=0.
REQ-034 SHALL test reset mid-check: reset asserted in S_CHK_HI -> all registers 0 next cycle; in_port held high -> rise captured after 2+DEBOUNCE_CYCLES cycles.

Source files
------------

// File: rtl/usb_gpx_pkg.sv
// Shared register map, EDGE/MASK bit positions and debounce state encoding for the GPX event block.
package usb_gpx_pkg;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_MASK  = 2'd1;
    localparam logic [1:0] ADDR_EDGE  = 2'd2;
    localparam logic [1:0] ADDR_COUNT = 2'd3;

    localparam int DATA_LEVEL_BIT = 0;
    localparam int DATA_RAW_BIT   = 1;

    localparam int EDGE_RISE_BIT = 0;
    localparam int EDGE_FALL_BIT = 1;

    typedef enum logic [1:0] {
        S_LO     = 2'd0,
        S_CHK_HI = 2'd1,
        S_HI     = 2'd2,
        S_CHK_LO = 2'd3
    } gpx_deb_state_t;

endpackage

// File: rtl/usb_gpx_debounce.sv
// GPX pin 2-flop synchronizer plus optional debounce (USB_GPX_DEBOUNCE_EN); level lags the pin by
// 2 cycles, or 2+DEBOUNCE_CYCLES when debounced. rise/fall pulse for one cycle with the level change.
module usb_gpx_debounce
    import usb_gpx_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic in_port,
    output logic sync,
    output logic level,
    output logic rise,
    output logic fall
);

    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    assign sync = r_sync2;

`ifdef USB_GPX_DEBOUNCE_EN
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_cfg
        $error("usb_gpx_debounce: DEBOUNCE_CYCLES must be 2..255");
    end

    // The entry transition already counts one sample, so the last stable sample is N-1.
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    gpx_deb_state_t r_state;
    gpx_deb_state_t w_state_nxt;
    logic [7:0]     r_cnt;
    logic [7:0]     w_cnt_nxt;
    logic           r_level;
    logic           w_level_nxt;
    logic           r_rise;
    logic           r_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LO;
            r_cnt   <= 8'd0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_rise  <= w_level_nxt & ~r_level;
            r_fall  <= ~w_level_nxt & r_level;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        case (r_state)
            S_LO: begin
                if (r_sync2) begin
                    w_state_nxt = S_CHK_HI;
                    w_cnt_nxt   = 8'd1;
                end
            end
            S_CHK_HI: begin
                if (!r_sync2) begin
                    w_state_nxt = S_LO;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_HI;
                    w_level_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            S_HI: begin
                if (!r_sync2) begin
                    w_state_nxt = S_CHK_LO;
                    w_cnt_nxt   = 8'd1;
                end
            end
            S_CHK_LO: begin
                if (r_sync2) begin
                    w_state_nxt = S_HI;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_LO;
                    w_level_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = S_LO;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    logic r_sync_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync_d <= 1'b0;
        end else begin
            r_sync_d <= r_sync2;
        end
    end

    assign level = r_sync2;
    assign rise  = r_sync2 & ~r_sync_d;
    assign fall  = ~r_sync2 & r_sync_d;
`endif

endmodule

// File: rtl/usb_gpx_event_ctrl.sv
// Avalon-MM GPX event capture (DATA/MASK/EDGE/COUNT) with level irq; debounce via USB_GPX_DEBOUNCE_EN.
// readdata registered 1 cycle after read, irq 1 cycle after EDGE; no wait states, never backpressures.
module usb_gpx_event_ctrl
    import usb_gpx_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        in_port,
    output logic        irq
);

    if (CNT_W < 8 || CNT_W > 32) begin : g_bad_cfg
        $error("usb_gpx_event_ctrl: CNT_W must be 8..32");
    end

    logic             w_sync;
    logic             w_level;
    logic             w_rise;
    logic             w_fall;
    logic             w_pulse;
    logic [1:0]       w_edge_set;
    logic [1:0]       w_edge_clr;
    logic             w_wr_mask;
    logic             w_wr_edge;
    logic             w_wr_count;
    logic [31:0]      w_rd_dat;
    logic             w_unused_wdata;

    logic [1:0]       r_mask;
    logic [1:0]       r_edge;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_readdata;
    logic             r_irq;

    usb_gpx_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .in_port(in_port),
        .sync   (w_sync),
        .level  (w_level),
        .rise   (w_rise),
        .fall   (w_fall)
    );

    assign w_wr_mask  = write && (address == ADDR_MASK);
    assign w_wr_edge  = write && (address == ADDR_EDGE);
    assign w_wr_count = write && (address == ADDR_COUNT);
    assign w_pulse    = w_rise | w_fall;

    always_comb begin
        w_edge_set                = 2'b00;
        w_edge_set[EDGE_RISE_BIT] = w_rise;
        w_edge_set[EDGE_FALL_BIT] = w_fall;
    end

    assign w_edge_clr     = w_wr_edge ? writedata[1:0] : 2'b00;
    assign w_unused_wdata = ^writedata[31:2];

    always_comb begin
        w_rd_dat = 32'd0;
        case (address)
            ADDR_DATA: begin
                w_rd_dat[DATA_LEVEL_BIT] = w_level;
                w_rd_dat[DATA_RAW_BIT]   = w_sync;
            end
            ADDR_MASK:  w_rd_dat[1:0] = r_mask;
            ADDR_EDGE:  w_rd_dat[1:0] = r_edge;
            ADDR_COUNT: w_rd_dat      = 32'(r_count);
            default:    w_rd_dat      = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask     <= 2'b00;
            r_edge     <= 2'b00;
            r_count    <= '0;
            r_readdata <= 32'd0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr_mask) begin
                r_mask <= writedata[1:0];
            end
            // Set is OR-ed in after the clear so a coincident pulse is never lost.
            r_edge <= (r_edge & ~w_edge_clr) | w_edge_set;
            if (w_wr_count) begin
                r_count <= w_pulse ? CNT_W'(1) : '0;
            end else if (w_pulse && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + CNT_W'(1);
            end
            r_irq <= |(r_edge & r_mask);
            if (read) begin
                r_readdata <= w_rd_dat;
            end
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_usb_gpx_event_ctrl.sv
// Bench for usb_gpx_event_ctrl with DEBOUNCE_CYCLES=4, CNT_W=8, directed scenarios plus random traffic.
module tb_usb_gpx_event_ctrl;

    localparam int DEB = 4;
    localparam int CW  = 8;
`ifdef USB_GPX_DEBOUNCE_EN
    localparam int DEB_EN = 1;
`else
    localparam int DEB_EN = 0;
`endif
    localparam int LAT              = (DEB_EN != 0) ? (2 + DEB) : 2;
    localparam int EXP_GLITCH_LVL   = (DEB_EN != 0) ? 0 : 1;
    localparam int EXP_GLITCH_EDGE  = (DEB_EN != 0) ? 0 : 3;
    localparam int EXP_GLITCH_COUNT = (DEB_EN != 0) ? 0 : 2;
    localparam int CNT_MAX          = (1 << CW) - 1;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        in_port;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;
    logic cur_in = 1'b0;

    // Reference model state, as visible just after each clock edge.
    logic        m_s1, m_s2;
    logic        m_level, m_rise, m_fall;
    logic [1:0]  m_mask, m_edge;
    int          m_count;
    logic        m_irq;
    logic [31:0] m_rd;
    bit          m_win[$];

    usb_gpx_event_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .address  (address),
        .read     (read),
        .write    (write),
        .writedata(writedata),
        .readdata (readdata),
        .in_port  (in_port),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bus cycle, advance the model across the edge, then settle 1 time unit.
    task automatic cyc(input logic inp, input logic rd, input logic wr,
                       input logic [1:0] a, input logic [31:0] wd, input logic rst);
        logic       sp, lp, pulse;
        logic [1:0] nedge;
        bit         all_new;
        in_port   = inp;
        read      = rd;
        write     = wr;
        address   = a;
        writedata = wd;
        reset     = rst;
        @(posedge clk);
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_rise = 0; m_fall = 0;
            m_mask = 0; m_edge = 0; m_count = 0; m_irq = 0; m_rd = 0;
            m_win.delete();
        end else begin
            sp = m_s2;
            lp = m_level;
            pulse = m_rise | m_fall;
            if (rd) begin
                case (a)
                    2'd0:    m_rd = {30'd0, sp, lp};
                    2'd1:    m_rd = {30'd0, m_mask};
                    2'd2:    m_rd = {30'd0, m_edge};
                    default: m_rd = 32'(m_count);
                endcase
            end
            m_irq = |(m_edge & m_mask);
            nedge = m_edge;
            if (wr && a == 2'd2) nedge = nedge & ~wd[1:0];
            nedge = nedge | {m_fall, m_rise};
            if (wr && a == 2'd1) m_mask = wd[1:0];
            if (wr && a == 2'd3) m_count = pulse ? 1 : 0;
            else if (pulse && m_count < CNT_MAX) m_count = m_count + 1;
            m_edge = nedge;
            m_s2 = m_s1;
            m_s1 = inp;
`ifdef USB_GPX_DEBOUNCE_EN
            // Level flips once the last DEB synchronized samples all disagree with it.
            m_win.push_back(sp);
            if (m_win.size() > DEB) void'(m_win.pop_front());
            if (m_win.size() == DEB) begin
                all_new = 1;
                foreach (m_win[i]) if (m_win[i] == lp) all_new = 0;
                if (all_new) m_level = ~lp;
            end
`else
            all_new = 0;
            m_level = m_s2;
`endif
            m_rise = m_level & ~lp;
            m_fall = ~m_level & lp;
        end
        #1;
    endtask

    task automatic idle();
        cyc(cur_in, 0, 0, 2'd0, 32'd0, 0);
    endtask

    task automatic rd(input logic [1:0] a);
        cyc(cur_in, 1, 0, a, 32'd0, 0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cyc(cur_in, 0, 1, a, d, 0);
    endtask

    task automatic do_reset();
        cur_in = 1'b0;
        cyc(0, 0, 0, 2'd0, 32'd0, 1);
        idle();
    endtask

    task automatic test_reset();
        logic [1:0] a;
        cyc(0, 0, 0, 2'd0, 32'd0, 1);
        cyc(0, 0, 0, 2'd0, 32'd0, 1);
        n_tests++;
        if (readdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_readdata: got %0h expected 0", readdata);
        end
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq: got %0b expected 0", irq);
        end
        for (int i = 0; i < 4; i++) begin
            a = 2'(i);
            rd(a);
            n_tests++;
            if (readdata !== 32'd0) begin
                n_fail++; $display("FAIL reset_reg%0d: got %0h expected 0", i, readdata);
            end
        end
    endtask

    task automatic test_debounce_accept();
        int first = 0;
        do_reset();
        cur_in = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            rd(2'd0);
            n_tests++;
            if (readdata !== m_rd) begin
                n_fail++; $display("FAIL accept_data_c%0d: got %0h expected %0h", k, readdata, m_rd);
            end
            if (first == 0 && readdata[0] === 1'b1) first = k;
        end
        n_tests++;
        if (first != LAT + 1) begin
            n_fail++; $display("FAIL accept_latency: got %0d expected %0d", first, LAT + 1);
        end
        rd(2'd2);
        n_tests++;
        if (readdata !== 32'd1) begin
            n_fail++; $display("FAIL accept_edge: got %0h expected 1", readdata);
        end
        rd(2'd3);
        n_tests++;
        if (readdata !== 32'd1) begin
            n_fail++; $display("FAIL accept_count: got %0h expected 1", readdata);
        end
    endtask

    task automatic test_glitch();
        int saw_hi = 0;
        do_reset();
        cur_in = 1'b1;
        repeat (3) idle();
        cur_in = 1'b0;
        for (int k = 0; k < 12; k++) begin
            rd(2'd0);
            n_tests++;
            if (readdata !== m_rd) begin
                n_fail++; $display("FAIL glitch_data_c%0d: got %0h expected %0h", k, readdata, m_rd);
            end
            if (readdata[0] === 1'b1) saw_hi = 1;
        end
        n_tests++;
        if (saw_hi != EXP_GLITCH_LVL) begin
            n_fail++; $display("FAIL glitch_level: got %0d expected %0d", saw_hi, EXP_GLITCH_LVL);
        end
        rd(2'd2);
        n_tests++;
        if (readdata !== 32'(EXP_GLITCH_EDGE)) begin
            n_fail++; $display("FAIL glitch_edge: got %0h expected %0h", readdata, EXP_GLITCH_EDGE);
        end
        rd(2'd3);
        n_tests++;
        if (readdata !== 32'(EXP_GLITCH_COUNT)) begin
            n_fail++; $display("FAIL glitch_count: got %0h expected %0h", readdata, EXP_GLITCH_COUNT);
        end
    endtask

    task automatic test_interrupt();
        int h;
        int seen = 0;
        do_reset();
        wr(2'd1, 32'h2);
        cur_in = 1'b1;
        h = LAT + 2 + int'($urandom_range(0, 3));
        for (int k = 0; k < h; k++) begin
            idle();
            n_tests++;
            if (irq !== 1'b0 || irq !== m_irq) begin
                n_fail++; $display("FAIL irq_during_rise_c%0d: got %0b expected 0", k, irq);
            end
        end
        cur_in = 1'b0;
        for (int k = 0; k < LAT + 8; k++) begin
            idle();
            n_tests++;
            if (irq !== m_irq) begin
                n_fail++; $display("FAIL irq_after_fall_c%0d: got %0b expected %0b", k, irq, m_irq);
            end
            if (irq === 1'b1) begin
                seen = 1;
                break;
            end
        end
        n_tests++;
        if (seen != 1) begin
            n_fail++; $display("FAIL irq_on_fall: got %0d expected 1", seen);
        end
        wr(2'd2, 32'h2);
        idle();
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_after_w1c: got %0b expected 0", irq);
        end
        rd(2'd2);
        n_tests++;
        if (readdata !== 32'h1) begin
            n_fail++; $display("FAIL edge_after_w1c: got %0h expected 1", readdata);
        end
    endtask

    task automatic test_set_wins();
        do_reset();
        cur_in = 1'b1;
        for (int k = 0; k < LAT + 6 && !m_rise; k++) idle();
        wr(2'd2, 32'h1);
        rd(2'd2);
        n_tests++;
        if (readdata !== 32'h1 || readdata !== m_rd) begin
            n_fail++; $display("FAIL set_wins_edge: got %0h expected 1", readdata);
        end
        cur_in = 1'b0;
        for (int k = 0; k < LAT + 6 && !m_fall; k++) idle();
        wr(2'd3, 32'h0);
        rd(2'd3);
        n_tests++;
        if (readdata !== 32'h1 || readdata !== m_rd) begin
            n_fail++; $display("FAIL clear_with_edge_count: got %0h expected 1", readdata);
        end
    endtask

    task automatic test_saturation();
        int h;
        do_reset();
        for (int e = 0; e < 300; e++) begin
            cur_in = ~cur_in;
            h = DEB + int'($urandom_range(0, 2));
            repeat (h) idle();
        end
        repeat (LAT + 4) idle();
        rd(2'd3);
        n_tests++;
        if (readdata !== 32'(CNT_MAX) || readdata !== m_rd) begin
            n_fail++; $display("FAIL count_saturate: got %0h expected %0h", readdata, CNT_MAX);
        end
        wr(2'd3, $urandom);
        rd(2'd3);
        n_tests++;
        if (readdata !== 32'd0) begin
            n_fail++; $display("FAIL count_clear: got %0h expected 0", readdata);
        end
    endtask

    task automatic test_reset_mid_check();
        int first = 0;
        do_reset();
        wr(2'd1, 32'h3);
        cur_in = 1'b1;
        repeat (3) idle();
        cyc(1, 0, 0, 2'd0, 32'd0, 1);
        n_tests++;
        if (readdata !== 32'd0 || irq !== 1'b0) begin
            n_fail++; $display("FAIL midcheck_reset: got rd=%0h irq=%0b expected 0/0", readdata, irq);
        end
        for (int k = 1; k <= LAT + 6; k++) begin
            rd(2'd2);
            n_tests++;
            if (readdata !== m_rd || irq !== m_irq) begin
                n_fail++;
                $display("FAIL midcheck_poll_c%0d: got rd=%0h irq=%0b expected %0h/%0b", k, readdata, irq, m_rd, m_irq);
            end
            if (first == 0 && readdata[0] === 1'b1) first = k;
        end
        n_tests++;
        if (first != LAT + 2) begin
            n_fail++; $display("FAIL midcheck_rise_latency: got %0d expected %0d", first, LAT + 2);
        end
        rd(2'd1);
        n_tests++;
        if (readdata !== 32'd0) begin
            n_fail++; $display("FAIL midcheck_mask: got %0h expected 0", readdata);
        end
        rd(2'd3);
        n_tests++;
        if (readdata !== 32'd1) begin
            n_fail++; $display("FAIL midcheck_count: got %0h expected 1", readdata);
        end
    endtask

    task automatic test_random();
        int         run = 0;
        int         r;
        logic [1:0] a;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (run == 0) begin
                cur_in = 1'($urandom_range(0, 1));
                run    = int'($urandom_range(1, 8));
            end
            run--;
            r = int'($urandom_range(0, 7));
            a = 2'($urandom_range(0, 3));
            cyc(cur_in, r < 6, r == 7, a, $urandom, 0);
            n_tests++;
            if (readdata !== m_rd) begin
                n_fail++; $display("FAIL random_readdata_c%0d: got %0h expected %0h", i, readdata, m_rd);
            end
            n_tests++;
            if (irq !== m_irq) begin
                n_fail++; $display("FAIL random_irq_c%0d: got %0b expected %0b", i, irq, m_irq);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        read      = 1'b0;
        write     = 1'b0;
        address   = 2'd0;
        writedata = 32'd0;
        in_port   = 1'b0;
        test_reset();
        test_debounce_accept();
        test_glitch();
        test_interrupt();
        test_set_wins();
        test_saturation();
        test_reset_mid_check();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
